// File: rtl/ofmap_col2im_writer_if.sv
// Bundles the control, GEMM stream and feature-map write-port signals of the col2im writer.
interface ofmap_col2im_writer_if #(
    parameter int BW = 16,
    parameter int AW = 16
) ();
    logic          start;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;
    logic          err;
    logic          s_valid;
    logic          s_ready;
    logic [BW-1:0] s_data;
    logic          s_last;
    logic          mem_we;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;

    modport master (
        output start, base_addr, s_valid, s_data, s_last, mem_ready,
        input  busy, done, err, s_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  start, base_addr, s_valid, s_data, s_last, mem_ready,
        output busy, done, err, s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ofmap_col2im_writer.sv
// Scatters a row-major GEMM result stream into a zero-padded [K][OP][OP] ofmap in memory,
// writing the pad border first so the memory holds the next layer's padded ifmap.
module ofmap_col2im_writer #(
    parameter int K  = 4,
    parameter int OH = 8,
    parameter int P  = 1,
    parameter int BW = 16,
    parameter int AW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ofmap_col2im_writer_if.slave bus
);
    localparam int OP    = OH + 2 * P;
    localparam int PLANE = OP * OP;
    localparam int CW    = $clog2(OP + 1) + 1;
    localparam int KW    = $clog2(K + 1) + 1;

    localparam logic [CW-1:0] C_P       = CW'(P);
    localparam logic [CW-1:0] C_OH      = CW'(OH);
    localparam logic [CW-1:0] C_OH_LAST = CW'(OH - 1);
    localparam logic [CW-1:0] C_OP_LAST = CW'(OP - 1);
    localparam logic [KW-1:0] C_K_LAST  = KW'(K - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAD   = 2'd1,
        DATA  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [BW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;

    logic out_free_s;
    logic accept_s;
    logic border_s;
    logic final_s;

    function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base,
                                              input logic [KW-1:0] k,
                                              input logic [CW-1:0] r,
                                              input logic [CW-1:0] c);
        addr_of = base + AW'(k) * AW'(PLANE) + AW'(r) * AW'(OP) + AW'(c);
    endfunction

    // Unsigned wrap makes (x - P) < OH true exactly for interior coordinates.
    assign border_s   = !(((r_q - C_P) < C_OH) && ((c_q - C_P) < C_OH));
    assign out_free_s = !we_q || bus.mem_ready;
    assign accept_s   = (state_q == DATA) && bus.s_valid && out_free_s;
    assign final_s    = (k_q == C_K_LAST) && (r_q == C_OH_LAST) && (c_q == C_OH_LAST);

    assign bus.s_ready   = (state_q == DATA) && out_free_s;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // Next-state, scan counters and output-register load decisions.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q && !bus.mem_ready;
        done_d  = 1'b0;
        err_d   = err_q;
        k_d     = k_q;
        r_d     = r_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_addr;
                    err_d   = 1'b0;
                    k_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    state_d = (P > 0) ? PAD : DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            PAD: begin
                if (out_free_s) begin
                    if (border_s) begin
                        we_d    = 1'b1;
                        addr_d  = addr_of(base_q, k_q, r_q, c_q);
                        wdata_d = '0;
                    end else begin
                        we_d = 1'b0;
                    end
                    if (c_q == C_OP_LAST) begin
                        c_d = '0;
                        if (r_q == C_OP_LAST) begin
                            r_d = '0;
                            if (k_q == C_K_LAST) begin
                                k_d     = '0;
                                state_d = DATA;
                            end else begin
                                k_d = k_q + 1'b1;
                            end
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end else begin
                    state_d = PAD;
                end
            end
            DATA: begin
                if (accept_s) begin
                    we_d    = 1'b1;
                    wdata_d = bus.s_data;
                    addr_d  = addr_of(base_q, k_q, r_q + C_P, c_q + C_P);
                    if (bus.s_last != final_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    // Beat count alone decides the end of the matrix.
                    if (c_q == C_OH_LAST) begin
                        c_d = '0;
                        if (r_q == C_OH_LAST) begin
                            r_d = '0;
                            if (k_q == C_K_LAST) begin
                                k_d     = '0;
                                state_d = FLUSH;
                            end else begin
                                k_d = k_q + 1'b1;
                            end
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            FLUSH: begin
                if (out_free_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any pending write at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            k_q     <= k_d;
            r_q     <= r_d;
            c_q     <= c_d;
        end
    end
endmodule

// File: tb/tb_ofmap_col2im_writer.sv
// Directed scoreboard bench: a padded instance (K=2,oH=2,P=1) and an unpadded one (K=1,oH=3,P=0).
module tb_ofmap_col2im_writer;
    logic clk;
    logic rst;
    logic tgl;
    logic tog_a;
    logic rdy_a;
    logic rdy_b;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_a [$];
    logic [31:0] q_b [$];
    int pad_off [12];
    int dat_off [8];

    int wr_a = 0, done_a = 0, wr_b = 0, done_b = 0, run_b = 0, max_b = 0;
    logic stall_a = 1'b0;
    logic [15:0] hold_addr_a = 16'h0000, hold_data_a = 16'h0000;
    logic [31:0] e_a, e_b;

    ofmap_col2im_writer_if #(.BW(16), .AW(16)) ia ();
    ofmap_col2im_writer_if #(.BW(16), .AW(16)) ib ();

    assign ia.mem_ready = tog_a ? tgl : rdy_a;
    assign ib.mem_ready = rdy_b;

    ofmap_col2im_writer #(.K(2), .OH(2), .P(1), .BW(16), .AW(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ia)
    );
    ofmap_col2im_writer #(.K(1), .OH(3), .P(0), .BW(16), .AW(16)) dut_b (
        .clk(clk), .rst(rst), .bus(ib)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tgl = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tgl = ~tgl;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor for instance A: scoreboard pop, stall stability, done counting.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_a = 1'b0;
            end else begin
                if (stall_a) begin
                    check("a_hold_we", 32'(ia.mem_we), 32'd1);
                    check("a_hold_addr", 32'(ia.mem_addr), 32'(hold_addr_a));
                    check("a_hold_data", 32'(ia.mem_wdata), 32'(hold_data_a));
                end
                if (ia.mem_we && ia.mem_ready) begin
                    wr_a++;
                    check("a_expected_write", 32'(q_a.size() > 0), 32'd1);
                    if (q_a.size() > 0) begin
                        e_a = q_a.pop_front();
                        check("a_addr", 32'(ia.mem_addr), 32'(e_a[31:16]));
                        check("a_data", 32'(ia.mem_wdata), 32'(e_a[15:0]));
                    end
                end
                stall_a = ia.mem_we && !ia.mem_ready;
                if (stall_a) begin
                    hold_addr_a = ia.mem_addr;
                    hold_data_a = ia.mem_wdata;
                    check("a_stall_sready", 32'(ia.s_ready), 32'd0);
                end
                if (ia.done) done_a++;
            end
        end
    end

    // Monitor for instance B: scoreboard pop and mem_we run length.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ib.mem_we && ib.mem_ready) begin
                    wr_b++;
                    check("b_expected_write", 32'(q_b.size() > 0), 32'd1);
                    if (q_b.size() > 0) begin
                        e_b = q_b.pop_front();
                        check("b_addr", 32'(ib.mem_addr), 32'(e_b[31:16]));
                        check("b_data", 32'(ib.mem_wdata), 32'(e_b[15:0]));
                    end
                end
                if (ib.mem_we) run_b++;
                else run_b = 0;
                if (run_b > max_b) max_b = run_b;
                if (ib.done) done_b++;
            end
        end
    end

    task automatic send_a(input logic [15:0] d, input logic l, input logic [15:0] ea);
        int n;
        logic acc;
        ia.s_valid = 1'b1;
        ia.s_data  = d;
        ia.s_last  = l;
        q_a.push_back({ea, d});
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = ia.s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("a_accept", 32'(acc), 32'd1);
    endtask

    task automatic send_b(input logic [15:0] d, input logic l, input logic [15:0] ea);
        int n;
        logic acc;
        ib.s_valid = 1'b1;
        ib.s_data  = d;
        ib.s_last  = l;
        q_b.push_back({ea, d});
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = ib.s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("b_accept", 32'(acc), 32'd1);
    endtask

    task automatic push_pad_a(input logic [15:0] base);
        for (int i = 0; i < 24; i++)
            q_a.push_back({16'(int'(base) + pad_off[i % 12] + 16 * (i / 12)), 16'h0000});
    endtask

    task automatic start_a(input logic [15:0] base);
        ia.base_addr = base;
        ia.start     = 1'b1;
        @(posedge clk);
        #1;
        ia.start     = 1'b0;
    endtask

    task automatic run_a(input logic [15:0] base, input int last_at);
        int d0, w0, n;
        push_pad_a(base);
        d0 = done_a;
        w0 = wr_a;
        start_a(base);
        check("a_busy_after_start", 32'(ia.busy), 32'd1);
        check("a_err_cleared", 32'(ia.err), 32'd0);
        @(posedge clk);
        #1;
        start_a(base + 16'd7);
        for (int i = 0; i < 8; i++)
            send_a(16'(32'hA000 + i + int'(base)), 1'(i == last_at), 16'(int'(base) + dat_off[i]));
        ia.s_valid = 1'b0;
        ia.s_last  = 1'b0;
        n = 0;
        while (!ia.done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("a_done_seen", 32'(ia.done), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("a_done_once", 32'(done_a - d0), 32'd1);
        check("a_write_count", 32'(wr_a - w0), 32'd32);
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("a_err", 32'(ia.err), 32'(last_at != 7));
        check("a_idle", 32'(ia.busy), 32'd0);
    endtask

    initial begin
        pad_off = '{0, 1, 2, 3, 4, 7, 8, 11, 12, 13, 14, 15};
        dat_off = '{5, 6, 9, 10, 21, 22, 25, 26};
        rst   = 1'b1;
        tog_a = 1'b0;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        ia.start = 1'b0; ia.base_addr = 16'h0000; ia.s_valid = 1'b0; ia.s_data = 16'h0000; ia.s_last = 1'b0;
        ib.start = 1'b0; ib.base_addr = 16'h0000; ib.s_valid = 1'b0; ib.s_data = 16'h0000; ib.s_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(ia.busy), 32'd0);
        check("rst_done", 32'(ia.done), 32'd0);
        check("rst_err", 32'(ia.err), 32'd0);
        check("rst_sready", 32'(ia.s_ready), 32'd0);
        check("rst_we", 32'(ia.mem_we), 32'd0);
        check("rst_addr", 32'(ia.mem_addr), 32'd0);
        check("rst_wdata", 32'(ia.mem_wdata), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Padded run at base 0, memory always ready.
        run_a(16'd0, 7);

        // Base 100 with mem_ready toggling every cycle.
        tog_a = 1'b1;
        run_a(16'd100, 7);
        tog_a = 1'b0;

        // s_last on beat 3 of 8, then a clean run that must clear err.
        run_a(16'd0, 2);
        run_a(16'd0, 7);

        // Reset during DATA with a write pending, then a full replay.
        push_pad_a(16'd0);
        start_a(16'd0);
        for (int i = 0; i < 3; i++)
            send_a(16'(32'hB000 + i), 1'b0, 16'(dat_off[i]));
        ia.s_valid = 1'b0;
        check("pre_rst_we", 32'(ia.mem_we), 32'd1);
        check("pre_rst_sready", 32'(ia.s_ready), 32'd1);
        check("pre_rst_busy", 32'(ia.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_we", 32'(ia.mem_we), 32'd0);
        check("mid_rst_busy", 32'(ia.busy), 32'd0);
        check("mid_rst_sready", 32'(ia.s_ready), 32'd0);
        q_a.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_a(16'd0, 7);

        // Unpadded instance: 9 back-to-back beats, addresses 0..8.
        begin
            int d0, n;
            d0 = done_b;
            ib.base_addr = 16'd0;
            ib.start     = 1'b1;
            @(posedge clk);
            #1;
            ib.start     = 1'b0;
            for (int i = 0; i < 9; i++)
                send_b(16'(i + 1), 1'(i == 8), 16'(i));
            ib.s_valid = 1'b0;
            ib.s_last  = 1'b0;
            n = 0;
            while (!ib.done && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("b_done_seen", 32'(ib.done), 32'd1);
            repeat (3) @(posedge clk);
            #1;
            check("b_done_once", 32'(done_b - d0), 32'd1);
            check("b_write_count", 32'(wr_b), 32'd9);
            check("b_queue_drained", 32'(q_b.size()), 32'd0);
            check("b_consecutive_we", 32'(max_b), 32'd9);
            check("b_err", 32'(ib.err), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
